fft_loader: RTL and testbench

- Input-side writer for the FFT sample memory.
- Accepts a stream of complex Q1.15 samples over a valid/ready handshake and writes each sample to bit-reversed order across the two even/odd segment banks (mem1/mem2).
- When all N samples have landed, pulses start to the FFT control and holds off new loads until the transform completes.

---
 rtl/fft_pkg.sv | 38 +++
 rtl/fft_loader_if.sv | 16 +
 rtl/fft_bitrev_addr.sv | 24 ++
 rtl/fft_loader.sv | 124 ++++++++++++
 tb/tb_fft_loader.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_pkg : shared FFT constants, sample types, loader states, bitrev |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fft_pkg;

    localparam int N_LOG2 = 10;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int N      = 1 << N_LOG2;
    localparam int IDX_W  = $clog2(N_LOG2);

    typedef logic signed [DATA_W-1:0] comp_t;
    typedef comp_t [1:0] cplx_t;  // [0] real, [1] imag

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4
    } loader_state_t;

    // Reverses the low 'width' bits of v; bits above 'width' return as zero.
    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v, input int width);
        logic [N_LOG2-1:0] r;
        r = '0;
        for (int i = 0; i < N_LOG2; i++) begin
            if (i < width) begin
                r[IDX_W'(i)] = v[IDX_W'(width - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_loader_if : valid/ready complex sample stream into the loader  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface fft_loader_if;

    logic          valid;
    logic          ready;
    fft_pkg::cplx_t data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface
`default_nettype wire

// File: rtl/fft_bitrev_addr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_bitrev_addr : sample index -> {bank, bank address}, bit-reversed|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fft_bitrev_addr
    import fft_pkg::*;
(
    input  wire [N_LOG2-1:0] i_n,
    output logic             o_bank,
    output logic [ADDR_W-1:0] o_addr
);

    logic [N_LOG2-1:0] w_rev;

    // LSB of the reversed index picks the even/odd segment bank.
    always_comb begin
        w_rev  = bitrev(i_n, N_LOG2);
        o_bank = w_rev[0];
        o_addr = w_rev[N_LOG2-1:1];
    end

endmodule
`default_nettype wire

// File: rtl/fft_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_loader : writes N streamed samples bit-reversed into mem1/mem2, |
// | then starts the FFT. Option macro: FFT_LOADER_PRESCALE_EN.          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fft_loader
    import fft_pkg::*;
(
    input  wire               i_clk,
    input  wire               i_rst,
    input  wire               i_en,
    input  wire               i_arm,
    fft_loader_if.slave       s_in,
    input  wire               i_fft_active,
    output logic [1:0]        o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output cplx_t             o_wr_data,
    output logic              o_start,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [N_LOG2-1:0] c_LAST = '1;

    loader_state_t       r_state;
    logic [N_LOG2-1:0]   r_count;
    logic [1:0]          r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    cplx_t               r_wr_data;
    logic                r_done;

    logic                w_accept;
    logic                w_bank;
    logic [ADDR_W-1:0]   w_addr;
    cplx_t               w_data;

    fft_bitrev_addr u_bitrev (
        .i_n    (r_count),
        .o_bank (w_bank),
        .o_addr (w_addr)
    );

    assign s_in.ready = i_en && (r_state == ST_LOAD);
    assign w_accept   = s_in.valid && s_in.ready;

`ifdef FFT_LOADER_PRESCALE_EN
    localparam logic signed [DATA_W:0] c_HALF_MAX = (DATA_W+1)'((1 << (DATA_W - 2)) - 1);

    // (x + 1) >>> 1; only x = max positive can overflow the halved range.
    function automatic comp_t halve_round(input comp_t x);
        logic signed [DATA_W:0] sum;
        sum = $signed({x[DATA_W-1], x}) + (DATA_W+1)'(1);
        sum = sum >>> 1;
        if (sum > c_HALF_MAX) begin
            return c_HALF_MAX[DATA_W-1:0];
        end
        return sum[DATA_W-1:0];
    endfunction

    always_comb begin
        w_data[0] = halve_round(s_in.data[0]);
        w_data[1] = halve_round(s_in.data[1]);
    end
`else
    assign w_data = s_in.data;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_wr_en   <= 2'b00;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
        end else if (i_en) begin
            r_wr_en <= 2'b00;
            r_done  <= 1'b0;
            if (w_accept) begin
                r_wr_en   <= w_bank ? 2'b10 : 2'b01;
                r_wr_addr <= w_addr;
                r_wr_data <= w_data;
                r_count   <= r_count + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_arm) begin
                        r_state <= ST_LOAD;
                        r_count <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept && (r_count == c_LAST)) begin
                        r_state <= ST_START;
                    end
                end
                ST_START:   r_state <= ST_WAIT_HI;
                ST_WAIT_HI: begin
                    if (i_fft_active) begin
                        r_state <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!i_fft_active) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    // Pulses are gated by the enable so a stalled cycle never issues a write or strobe.
    assign o_wr_en   = i_en ? r_wr_en : 2'b00;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_start   = i_en && (r_state == ST_START);
    assign o_busy    = (r_state != ST_IDLE);
    assign o_done    = i_en && r_done;

endmodule
`default_nettype wire

// File: tb/tb_fft_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fft_loader : directed self-checking bench for fft_loader         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fft_loader;
    import fft_pkg::*;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_en;
    logic              i_arm;
    logic              i_fft_active;
    logic [1:0]        o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    cplx_t             o_wr_data;
    logic              o_start;
    logic              o_busy;
    logic              o_done;

    fft_loader_if sif ();

    fft_loader dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_arm        (i_arm),
        .s_in         (sif),
        .i_fft_active (i_fft_active),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_start      (o_start),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    int passed = 0;
    int total  = 0;
    int failed = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int start_cnt = 0;
    int both_cnt = 0;

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_wr_en != 2'b00) wr_cnt++;
            if (o_wr_en == 2'b11) both_cnt++;
            if (o_done)  done_cnt++;
            if (o_start) start_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [9:0] ref_rev(input int n);
        logic [9:0] v;
        logic [9:0] r;
        v = 10'(n);
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r = {r[8:0], v[0]};
            v = v >> 1;
        end
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          w0;
        int          d0;
        int          s0;
        int          acc;
        int          cyc;
        logic        ready_seen;
        logic        en_v;
        logic        va;
        logic [1:0]  pend_en;
        logic [8:0]  pend_addr;
        logic [1:0]  exp_wr;
        logic [9:0]  rev;

        i_rst = 1'b1; i_en = 1'b1; i_arm = 1'b0; i_fft_active = 1'b0;
        sif.valid = 1'b0; sif.data = '0;
        #1;
        check("rst_wr_en", o_wr_en, 2'b00);
        check("rst_wr_addr", o_wr_addr, 0);
        check("rst_wr_data", o_wr_data, 0);
        check("rst_ctrl", {sif.ready, o_start, o_busy, o_done}, 4'b0000);
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;

        // valid while IDLE must not write
        sif.valid = 1'b1; sif.data = {16'sd5, 16'sd5};
        w0 = wr_cnt;
        repeat (4) tick;
        check("idle_valid_nowrite", wr_cnt - w0, 0);
        check("idle_ready", sif.ready, 1'b0);
        sif.valid = 1'b0;

        i_arm = 1'b1; tick; i_arm = 1'b0; #1;
        check("arm_busy", o_busy, 1'b1);
        check("load_ready", sif.ready, 1'b1);

        // full-rate frame, data {n, -n}
        w0 = wr_cnt; s0 = start_cnt;
        for (int n = 0; n < 1024; n++) begin
            sif.valid = 1'b1; sif.data[0] = 16'(n); sif.data[1] = 16'(-n);
            tick; #1;
            case (n)
                0:    begin check("n0_en", o_wr_en, 2'b01); check("n0_addr", o_wr_addr, 9'h000); end
                1:    begin check("n1_en", o_wr_en, 2'b01); check("n1_addr", o_wr_addr, 9'h100); end
                2:    begin
                          check("n2_en", o_wr_en, 2'b01); check("n2_addr", o_wr_addr, 9'h080);
`ifdef FFT_LOADER_PRESCALE_EN
                          check("n2_data", o_wr_data, 32'hFFFF_0001);
`else
                          check("n2_data", o_wr_data, 32'hFFFE_0002);
`endif
                      end
                500:  check("mid_ready", sif.ready, 1'b1);
                512:  begin check("n512_en", o_wr_en, 2'b10); check("n512_addr", o_wr_addr, 9'h000); end
                1023: begin
                          check("n1023_en", o_wr_en, 2'b10); check("n1023_addr", o_wr_addr, 9'h1FF);
                          check("start_with_last", o_start, 1'b1);
                          check("ready_after_last", sif.ready, 1'b0);
                      end
                default: ;
            endcase
        end
        sif.valid = 1'b0;
        tick;
        check("start_gone", o_start, 1'b0);
        check("wr_gone", o_wr_en, 2'b00);
        check("frame_writes", wr_cnt - w0, 1024);
        check("frame_starts", start_cnt - s0, 1);

        // FFT busy window; valid and a stray arm must be ignored
        i_fft_active = 1'b1; sif.valid = 1'b1;
        w0 = wr_cnt; d0 = done_cnt; ready_seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            i_arm = (c == 100);
            tick;
            ready_seen = ready_seen | sif.ready;
        end
        i_arm = 1'b0;
        check("wait_ready_low", ready_seen, 1'b0);
        check("wait_no_done", done_cnt - d0, 0);
        check("wait_busy", o_busy, 1'b1);
        i_fft_active = 1'b0;
        tick;
        check("done_pulse", o_done, 1'b1);
        check("done_idle", o_busy, 1'b0);
        tick;
        check("done_clear", o_done, 1'b0);
        check("done_once", done_cnt - d0, 1);
        check("wait_no_write", wr_cnt - w0, 0);
        sif.valid = 1'b0;

        // random valid and enable gaps
        i_arm = 1'b1; tick; i_arm = 1'b0;
        w0 = wr_cnt; acc = 0; cyc = 0; pend_en = 2'b00; pend_addr = '0;
        while (acc < 1024 && cyc < 20000) begin
            en_v = ($urandom_range(0, 3) != 0);
            va   = 1'($urandom_range(0, 1));
            i_en = en_v; sif.valid = va; sif.data = {16'(acc), 16'(acc)};
            #1;
            exp_wr = en_v ? pend_en : 2'b00;
            check("rnd_ready", sif.ready, en_v);
            check("rnd_wr_en", o_wr_en, exp_wr);
            if (exp_wr != 2'b00) check("rnd_wr_addr", o_wr_addr, pend_addr);
            if (en_v) begin
                if (va) begin
                    rev = ref_rev(acc);
                    pend_en = rev[0] ? 2'b10 : 2'b01;
                    pend_addr = rev[9:1];
                    acc++;
                end else begin
                    pend_en = 2'b00;
                end
            end
            tick;
            cyc++;
        end
        check("rnd_budget", acc, 1024);
        i_en = 1'b1; sif.valid = 1'b0;
        #1;
        check("rnd_last_wr", o_wr_en, pend_en);
        check("rnd_start", o_start, 1'b1);
        tick;
        check("rnd_writes", wr_cnt - w0, 1024);
        i_fft_active = 1'b1; tick; tick;
        i_fft_active = 1'b0; tick; tick;
        check("rnd_idle", o_busy, 1'b0);
        check("no_dual_write", both_cnt, 0);

        // asynchronous reset mid-frame
        i_arm = 1'b1; tick; i_arm = 1'b0;
        sif.valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            sif.data = {16'(n), 16'(n)};
            tick;
        end
        #2 i_rst = 1'b1;
        #1;
        check("arst_wr_en", o_wr_en, 2'b00);
        check("arst_wr_addr", o_wr_addr, 0);
        check("arst_wr_data", o_wr_data, 0);
        check("arst_ctrl", {sif.ready, o_start, o_busy, o_done}, 4'b0000);
        tick;
        i_rst = 1'b0; sif.valid = 1'b0;
        i_arm = 1'b1; tick; i_arm = 1'b0;

        sif.valid = 1'b1; sif.data[0] = 16'sd32767; sif.data[1] = -16'sd32768;
        tick;
        sif.data[0] = 16'sd3; sif.data[1] = -16'sd3;
        #1;
        check("rearm_n0_en", o_wr_en, 2'b01);
        check("rearm_n0_addr", o_wr_addr, 9'h000);
`ifdef FFT_LOADER_PRESCALE_EN
        check("rearm_n0_data", o_wr_data, 32'hC000_3FFF);
`else
        check("rearm_n0_data", o_wr_data, 32'h8000_7FFF);
`endif
        tick;
        check("rearm_n1_en", o_wr_en, 2'b01);
        check("rearm_n1_addr", o_wr_addr, 9'h100);
`ifdef FFT_LOADER_PRESCALE_EN
        check("rearm_n1_data", o_wr_data, 32'hFFFF_0002);
`else
        check("rearm_n1_data", o_wr_data, 32'hFFFD_0003);
`endif
        sif.valid = 1'b0;
        i_rst = 1'b1;
        tick;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
